// File: rtl/bias_sgd_update.sv
// bias_sgd_update: applies b[i] <= b[i] - lr*g[i] across a bias vector in
// memory, in signed Q16.16, through a single request/ack memory port.
//
// state  | meaning
// WAIT   | idle, waiting for go; parameters latched on go
// RD_B   | reading b[idx]
// RD_G   | reading g[idx]
// EX     | compute lr*g, subtract from b, saturate
// WB     | writing updated b[idx]
// DONE   | vector finished; held while go stays high
module bias_sgd_update #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] g_base,
  input  logic [DATA_W-1:0] lr,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int DIFF_W = 2 * DATA_W + 2;

  typedef enum logic [2:0] {
    S_WAIT, S_RD_B, S_RD_G, S_EX, S_WB, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx;
  logic [LEN_W-1:0]         idx_inc;
  logic [ADDR_W-1:0]        b_base_q;
  logic [ADDR_W-1:0]        g_base_q;
  logic [DATA_W-1:0]        lr_q;
  logic [DATA_W-1:0]        b_reg;
  logic [DATA_W-1:0]        g_reg;
  logic [DATA_W-1:0]        res_reg;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] prod_sh;
  logic [DIFF_W-1:0]        diff;
  logic [DATA_W-1:0]        sat;

  assign idx_inc = idx + LEN_W'(1);

  // Fixed-point update: full signed product, arithmetic shift back to Q16.16,
  // wide subtract so neither overflow direction can wrap, then clamp.
  always_comb begin
    prod_full = {{DATA_W{lr_q[DATA_W-1]}}, lr_q} * {{DATA_W{g_reg[DATA_W-1]}}, g_reg};
    prod_sh   = prod_full >>> FRAC_W;
    diff      = {{(DIFF_W-DATA_W){b_reg[DATA_W-1]}}, b_reg}
              - {{(DIFF_W-PROD_W){prod_sh[PROD_W-1]}}, prod_sh};
    sat       = diff[DATA_W-1:0];
    if (!(diff[DIFF_W-1:DATA_W-1] == '0 || diff[DIFF_W-1:DATA_W-1] == '1)) begin
      sat = diff[DIFF_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_l) state <= S_WAIT;
    else        state <= state_nxt;
  end

  // Job parameters, element index and operand/result capture.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      len_q    <= '0;
      idx      <= '0;
      b_base_q <= '0;
      g_base_q <= '0;
      lr_q     <= '0;
      b_reg    <= '0;
      g_reg    <= '0;
      res_reg  <= '0;
    end else begin
      case (state)
        S_WAIT: if (go) begin
          len_q    <= len;
          b_base_q <= b_base;
          g_base_q <= g_base;
          lr_q     <= lr;
          idx      <= '0;
        end
        S_RD_B: if (mem_ack) b_reg <= mem_rdata;
        S_RD_G: if (mem_ack) g_reg <= mem_rdata;
        S_EX:   res_reg <= sat;
        S_WB:   if (mem_ack) idx <= idx_inc;
        default: ;
      endcase
    end
  end

  // Next state and memory-port/done outputs decoded from registered state,
  // so request fields stay put until the ack cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_WAIT: begin
        if (go) state_nxt = (len == '0) ? S_DONE : S_RD_B;
      end
      S_RD_B: begin
        mem_req  = 1'b1;
        mem_addr = b_base_q + ADDR_W'(idx);
        if (mem_ack) state_nxt = S_RD_G;
      end
      S_RD_G: begin
        mem_req  = 1'b1;
        mem_addr = g_base_q + ADDR_W'(idx);
        if (mem_ack) state_nxt = S_EX;
      end
      S_EX: begin
        state_nxt = S_WB;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = b_base_q + ADDR_W'(idx);
        mem_wdata = res_reg;
        if (mem_ack) state_nxt = (idx_inc == len_q) ? S_DONE : S_RD_B;
      end
      S_DONE: begin
        done = 1'b1;
        if (!go) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_bias_sgd_update.sv
// Testbench for bias_sgd_update: behavioural memory with random ack delay,
// transaction log compared against a plain-arithmetic SGD reference.
module tb_bias_sgd_update;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        go;
  logic [15:0] len;
  logic [31:0] b_base, g_base, lr;
  logic        done, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] mem [logic [31:0]];
  txn_t        log_q[$];
  txn_t        exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          req_cycles = 0;
  int          max_delay = 0;
  bit          stall_en = 0;
  logic [31:0] stall_addr = '0;

  bit          in_txn = 0;
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  int          t_wait;

  bias_sgd_update dut (
    .clk(clk), .rst_l(rst_l), .go(go), .len(len), .b_base(b_base),
    .g_base(g_base), .lr(lr), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SGD step from the arithmetic definition, using 64-bit integers.
  function automatic logic [31:0] sgd_ref(input logic [31:0] b, input logic [31:0] g,
                                          input logic [31:0] r);
    longint p, d;
    p = longint'($signed(r)) * longint'($signed(g));
    p = p >>> 16;
    d = longint'($signed(b)) - p;
    if (d > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (d < -64'sh8000_0000) return 32'h8000_0000;
    return d[31:0];
  endfunction

  // Memory responder: decides ack half a cycle before the sampling edge.
  always @(negedge clk) begin
    logic [31:0] rd;
    if (!rst_l) begin
      mem_ack = 1'b0;
      in_txn  = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (!in_txn) begin
        in_txn  = 1;
        t_we    = mem_we;
        t_addr  = mem_addr;
        t_wdata = mem_wdata;
        t_wait  = int'($urandom_range(max_delay, 0));
      end else begin
        check("stable_addr", mem_addr, t_addr);
        check("stable_we", mem_we, t_we);
        if (t_we) check("stable_wdata", mem_wdata, t_wdata);
      end
      if (stall_en && t_we && t_addr == stall_addr) begin
        mem_ack = 1'b0;
      end else if (t_wait == 0) begin
        mem_ack = 1'b1;
        if (t_we) begin
          mem[t_addr] = t_wdata;
          log_q.push_back('{1'b1, t_addr, t_wdata});
        end else begin
          rd = mem.exists(t_addr) ? mem[t_addr] : 32'h0;
          mem_rdata = rd;
          log_q.push_back('{1'b0, t_addr, rd});
        end
        in_txn = 0;
      end else begin
        t_wait--;
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      in_txn  = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic build_expected(input int n, input logic [31:0] bb, input logic [31:0] gb,
                                input logic [31:0] r);
    logic [31:0] bv, gv;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bv = mem[bb + 32'(i)];
      gv = mem[gb + 32'(i)];
      exp_q.push_back('{1'b0, bb + 32'(i), bv});
      exp_q.push_back('{1'b0, gb + 32'(i), gv});
      exp_q.push_back('{1'b1, bb + 32'(i), sgd_ref(bv, gv, r)});
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check($sformatf("%s.count", tag), 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].we", tag, i), log_q[i].we, exp_q[i].we);
      check($sformatf("%s[%0d].addr", tag, i), log_q[i].addr, exp_q[i].addr);
      check($sformatf("%s[%0d].data", tag, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_job(input string tag, input int n, input logic [31:0] bb,
                         input logic [31:0] gb, input logic [31:0] r,
                         input int exp_lat, input bit keep_go);
    int cyc;
    int bound;
    log_q.delete();
    build_expected(n, bb, gb, r);
    len = 16'(n); b_base = bb; g_base = gb; lr = r;
    go = 1'b1;
    tick();
    if (!keep_go) go = 1'b0;
    len = '0; b_base = '0; g_base = '0; lr = '0;
    cyc = 0;
    bound = 4 * n * (max_delay + 1) + 20;
    while (!done && cyc < bound) begin
      tick();
      cyc++;
    end
    check({tag, ".done_reached"}, done, 1'b1);
    if (exp_lat >= 0) check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    compare_log(tag);
    if (!keep_go) begin
      tick();
      check({tag, ".back_to_wait"}, done, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] bb, gb, r;
    int          cyc;
    int          reqs_before;

    rst_l = 1'b0; go = 1'b0; len = '0; b_base = '0; g_base = '0; lr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("rst.done", done, 1'b0);
    check("rst.mem_req", mem_req, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    rst_l = 1'b1;
    tick();

    // Half learning rate on a unit gradient, zero-wait memory.
    max_delay = 0;
    mem[32'h100] = 32'h0001_0000;
    mem[32'h200] = 32'h0001_0000;
    run_job("t1", 1, 32'h100, 32'h200, 32'h0000_8000, 4, 0);
    check("t1.result", mem[32'h100], 32'h0000_8000);

    // Both saturation directions.
    mem[32'h300] = 32'h8000_0000; mem[32'h400] = 32'h0000_0001;
    mem[32'h301] = 32'h7FFF_8000; mem[32'h401] = 32'hFFFF_0000;
    run_job("t2", 2, 32'h300, 32'h400, 32'h0001_0000, 8, 0);
    check("t2.neg_sat", mem[32'h300], 32'h8000_0000);
    check("t2.pos_sat", mem[32'h301], 32'h7FFF_FFFF);

    // Empty vector: no memory traffic, done on the next cycle.
    reqs_before = req_cycles;
    len = '0; b_base = 32'h500; g_base = 32'h600; lr = 32'h0001_0000;
    go = 1'b1;
    tick();
    check("t3.done", done, 1'b1);
    check("t3.no_req", mem_req, 1'b0);
    go = 1'b0;
    tick();
    check("t3.back_to_wait", done, 1'b0);
    check("t3.no_traffic", 64'(req_cycles), 64'(reqs_before));

    // Random data with random ack delays, including an address wrap.
    max_delay = 3;
    for (int k = 0; k < 3; k++) begin
      bb = (k == 2) ? 32'hFFFF_FFFE : $urandom();
      gb = bb + 32'h0001_0000;
      r  = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
      for (int i = 0; i < 4; i++) begin
        mem[bb + 32'(i)] = $urandom();
        mem[gb + 32'(i)] = (i % 2 == 0) ? $urandom() : ($urandom_range(32'h0004_0000, 0) - 32'h0002_0000);
      end
      run_job($sformatf("t4_%0d", k), 4, bb, gb, r, -1, 0);
    end

    // Reset while the write of element 2 is stalled, then a clean rerun.
    max_delay = 0;
    bb = 32'h0000_7000; gb = 32'h0000_8000; r = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      mem[bb + 32'(i)] = $urandom();
      mem[gb + 32'(i)] = $urandom();
    end
    stall_en = 1; stall_addr = bb + 32'd2;
    len = 16'd4; b_base = bb; g_base = gb; lr = r;
    go = 1'b1;
    tick();
    go = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we && mem_addr == bb + 32'd2) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t5.reached_wb2", mem_req && mem_we && mem_addr == bb + 32'd2, 1'b1);
    rst_l = 1'b0;
    tick();
    check("t5.rst_req", mem_req, 1'b0);
    check("t5.rst_done", done, 1'b0);
    check("t5.rst_we", mem_we, 1'b0);
    check("t5.rst_addr", mem_addr, 32'h0);
    check("t5.rst_wdata", mem_wdata, 32'h0);
    rst_l = 1'b1;
    stall_en = 0;
    tick();
    check("t5.idle_req", mem_req, 1'b0);
    run_job("t5_rerun", 4, bb, gb, r, 16, 0);

    // go held through DONE: stays done with no new traffic.
    mem[32'h900] = 32'h0002_0000; mem[32'hA00] = 32'hFFFF_8000;
    run_job("t6", 1, 32'h900, 32'hA00, 32'h0001_0000, 4, 1);
    reqs_before = req_cycles;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6.hold_done%0d", i), done, 1'b1);
    end
    check("t6.no_traffic", 64'(req_cycles), 64'(reqs_before));
    go = 1'b0;
    tick();
    check("t6.release", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
